// File: rtl/keccak_pkg.sv
// Shared types, sizes and mode lookups for the Keccak squeeze-side serializer.
package keccak_pkg;

    localparam int STATE_W        = 1600;
    localparam int RATE_MAX       = 1344;
    localparam int WORD_W         = 32;
    localparam int D_W            = 11;
    localparam int RATE_WORDS_MAX = RATE_MAX / WORD_W;

    typedef enum logic [2:0] {
        CM_SHA3_224 = 3'd0,
        CM_SHA3_256 = 3'd1,
        CM_SHA3_384 = 3'd2,
        CM_SHA3_512 = 3'd3,
        CM_SHAKE128 = 3'd4,
        CM_SHAKE256 = 3'd5
    } cmode_e;

    localparam logic [5:0] SHA3_224_NO = 6'd7;
    localparam logic [5:0] SHA3_256_NO = 6'd8;
    localparam logic [5:0] SHA3_384_NO = 6'd12;
    localparam logic [5:0] SHA3_512_NO = 6'd16;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LEAD     = 3'd1,
        ST_STREAM   = 3'd2,
        ST_SQZ_WAIT = 3'd3,
        ST_DONE     = 3'd4
    } sqz_state_e;

    // Rate in 32-bit words. Invalid modes never stream, so any non-zero value is safe there.
    function automatic logic [5:0] rate_words(input logic [2:0] cm);
        logic [5:0] r;
        case (cm)
            CM_SHA3_224: r = 6'd36;
            CM_SHA3_256: r = 6'd34;
            CM_SHA3_384: r = 6'd26;
            CM_SHA3_512: r = 6'd18;
            CM_SHAKE128: r = 6'd42;
            CM_SHAKE256: r = 6'd34;
            default:     r = 6'd42;
        endcase
        return r;
    endfunction

    // Digest length in 32-bit words; SHAKE truncates d to whole words.
    function automatic logic [5:0] n_words(input logic [2:0] cm, input logic [D_W-1:0] dd);
        logic [5:0] n;
        case (cm)
            CM_SHA3_224: n = SHA3_224_NO;
            CM_SHA3_256: n = SHA3_256_NO;
            CM_SHA3_384: n = SHA3_384_NO;
            CM_SHA3_512: n = SHA3_512_NO;
            CM_SHAKE128,
            CM_SHAKE256: n = 6'(dd >> 5);
            default:     n = 6'd0;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/keccak_word_select.sv
// Picks word word_idx out of the latched rate bits and byte-swaps it so that
// the lowest-addressed byte lands in the most significant position.
module keccak_word_select
    import keccak_pkg::*;
(
    input  logic [RATE_MAX-1:0] rate_i,
    input  logic [5:0]          word_idx,
    output logic [WORD_W-1:0]   word_o
);

    logic [WORD_W-1:0] raw;

    // Decoded mux; indices beyond the rate return zero instead of reading past the vector.
    always_comb begin
        raw = '0;
        for (int w = 0; w < RATE_WORDS_MAX; w++) begin
            if (word_idx == 6'(w)) begin
                raw = rate_i[w*WORD_W +: WORD_W];
            end
        end
    end

    // Byte 4k sits in raw[7:0]; present it in word_o[31:24].
    always_comb begin
        word_o = {raw[7:0], raw[15:8], raw[23:16], raw[31:24]};
    end

endmodule

// File: rtl/keccak_squeeze_serializer.sv
// Squeeze-side output stage: latches the rate part of the permutation result and
// streams the digest as 32-bit words, framed by a lead-in beat and a finish pulse.
// Requests extra permutations when a SHAKE output outruns the rate.
//
// state     | meaning
// IDLE      | waiting for state_vld
// LEAD      | discarded lead-in beat (ready=1, data 0)
// STREAM    | one data word per cycle
// SQZ_WAIT  | squeeze_req issued, waiting for the next state_vld
// DONE      | finish_hash pulse, session closes next cycle
module keccak_squeeze_serializer
    import keccak_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic [2:0]          cmode,
    input  logic [D_W-1:0]      d,
    input  logic [STATE_W-1:0]  state_i,
    input  logic                state_vld,
    output logic                squeeze_req,
    output logic                busy,
    output logic                wr_en,
    output logic                ready,
    output logic [WORD_W-1:0]   dt_o_hash,
    output logic                finish_hash
);

    sqz_state_e          state_q, state_d;
    logic [2:0]          cmode_q, cmode_d;
    logic [D_W-1:0]      d_q, d_d;
    logic [RATE_MAX-1:0] rate_q, rate_d;
    logic [5:0]          word_idx_q, word_idx_d;
    logic [5:0]          total_q, total_d;

    logic                squeeze_req_q, squeeze_req_d;
    logic                busy_q, busy_d;
    logic                wr_en_q, wr_en_d;
    logic                ready_q, ready_d;
    logic [WORD_W-1:0]   dt_q, dt_d;
    logic                finish_q, finish_d;

    logic [5:0]          n_lat;
    logic [5:0]          r_lat;
    logic [WORD_W-1:0]   sel_word;
    logic                unused_state_hi;

    // Capacity bits are never output.
    assign unused_state_hi = ^state_i[STATE_W-1:RATE_MAX];

    assign n_lat = n_words(cmode_q, d_q);
    assign r_lat = rate_words(cmode_q);

    // Word for the coming cycle, taken from the next-state rate so a relatch is visible immediately.
    keccak_word_select u_word_select (
        .rate_i   (rate_d),
        .word_idx (word_idx_d),
        .word_o   (sel_word)
    );

    // Next-state, counter and latch logic.
    always_comb begin
        state_d    = state_q;
        cmode_d    = cmode_q;
        d_d        = d_q;
        rate_d     = rate_q;
        word_idx_d = word_idx_q;
        total_d    = total_q;
        case (state_q)
            ST_IDLE: begin
                if (state_vld) begin
                    cmode_d    = cmode;
                    d_d        = d;
                    rate_d     = state_i[RATE_MAX-1:0];
                    word_idx_d = '0;
                    total_d    = '0;
                    state_d    = (n_words(cmode, d) == 6'd0) ? ST_DONE : ST_LEAD;
                end
            end
            ST_LEAD: begin
                word_idx_d = '0;
                total_d    = '0;
                state_d    = ST_STREAM;
            end
            ST_STREAM: begin
                total_d = total_q + 6'd1;
                if (total_q == n_lat - 6'd1) begin
                    state_d = ST_DONE;
                end else if (word_idx_q == r_lat - 6'd1) begin
                    state_d = ST_SQZ_WAIT;
                end else begin
                    word_idx_d = word_idx_q + 6'd1;
                end
            end
            ST_SQZ_WAIT: begin
                if (state_vld) begin
                    rate_d     = state_i[RATE_MAX-1:0];
                    word_idx_d = '0;
                    state_d    = ST_STREAM;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state so they register alongside it.
    always_comb begin
        busy_d        = (state_d != ST_IDLE);
        wr_en_d       = (state_d != ST_IDLE);
        ready_d       = (state_d == ST_LEAD) || (state_d == ST_STREAM);
        dt_d          = (state_d == ST_STREAM) ? sel_word : '0;
        finish_d      = (state_d == ST_DONE);
        squeeze_req_d = (state_q == ST_STREAM) && (state_d == ST_SQZ_WAIT);
    end

    // State, latched copies, counters and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            cmode_q       <= '0;
            d_q           <= '0;
            rate_q        <= '0;
            word_idx_q    <= '0;
            total_q       <= '0;
            squeeze_req_q <= 1'b0;
            busy_q        <= 1'b0;
            wr_en_q       <= 1'b0;
            ready_q       <= 1'b0;
            dt_q          <= '0;
            finish_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            cmode_q       <= cmode_d;
            d_q           <= d_d;
            rate_q        <= rate_d;
            word_idx_q    <= word_idx_d;
            total_q       <= total_d;
            squeeze_req_q <= squeeze_req_d;
            busy_q        <= busy_d;
            wr_en_q       <= wr_en_d;
            ready_q       <= ready_d;
            dt_q          <= dt_d;
            finish_q      <= finish_d;
        end
    end

    assign squeeze_req = squeeze_req_q;
    assign busy        = busy_q;
    assign wr_en       = wr_en_q;
    assign ready       = ready_q;
    assign dt_o_hash   = dt_q;
    assign finish_hash = finish_q;

endmodule

// File: tb/tb_keccak_squeeze_serializer.sv
// Bench for keccak_squeeze_serializer: directed sessions plus random sessions,
// all checked against a digest-level model of the output stream.
module tb_keccak_squeeze_serializer;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [2:0]    cmode;
    logic [10:0]   d;
    logic [1599:0] state_i;
    logic          state_vld;
    logic          squeeze_req;
    logic          busy;
    logic          wr_en;
    logic          ready;
    logic [31:0]   dt_o_hash;
    logic          finish_hash;

    int total = 0;
    int bad   = 0;

    logic [1599:0] blk_q[$];
    logic [31:0]   got_q[$];
    logic [31:0]   t1_q[$];

    keccak_squeeze_serializer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cmode       (cmode),
        .d           (d),
        .state_i     (state_i),
        .state_vld   (state_vld),
        .squeeze_req (squeeze_req),
        .busy        (busy),
        .wr_en       (wr_en),
        .ready       (ready),
        .dt_o_hash   (dt_o_hash),
        .finish_hash (finish_hash)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Digest words: SHA3 digests are 224/256/384/512 bits, SHAKE gives floor(d/32).
    function automatic int ref_words(input int cm, input int dd);
        case (cm)
            0: return 224 / 32;
            1: return 256 / 32;
            2: return 384 / 32;
            3: return 512 / 32;
            4, 5: return dd / 32;
            default: return 0;
        endcase
    endfunction

    // Rate words from capacity: SHA3 capacity is twice the digest, SHAKE128/256 use 256/512.
    function automatic int ref_rate(input int cm);
        int cap;
        case (cm)
            0: cap = 448;
            1: cap = 512;
            2: cap = 768;
            3: cap = 1024;
            4: cap = 256;
            5: cap = 512;
            default: cap = 256;
        endcase
        return (1600 - cap) / 32;
    endfunction

    // Digest word k comes from squeeze block k/r, bytes 4*(k%r).. in big-endian order.
    function automatic logic [31:0] ref_word(input int k, input int r);
        logic [1599:0] b;
        int base;
        b = blk_q[k / r];
        base = 4 * (k % r);
        return {b[8*base +: 8], b[8*(base+1) +: 8], b[8*(base+2) +: 8], b[8*(base+3) +: 8]};
    endfunction

    function automatic logic [1599:0] ramp_blk(input bit inv);
        logic [1599:0] v;
        for (int i = 0; i < 200; i++) begin
            v[8*i +: 8] = inv ? 8'(8'hFF - i) : 8'(i);
        end
        return v;
    endfunction

    function automatic logic [1599:0] rand_blk();
        logic [1599:0] v;
        for (int i = 0; i < 50; i++) begin
            v[32*i +: 32] = $urandom;
        end
        return v;
    endfunction

    function automatic logic [31:0] got_at(input int i);
        if (i < got_q.size()) return got_q[i];
        return 32'hdeadbeef;
    endfunction

    // Runs one session: ready words land in got_q, then counts and timing are checked.
    task automatic run_session(input string name, input int cm, input int dd, input int gap,
                               input int disturb_at, input int rst_at);
        int n, r, exp_sq, exp_fin;
        int fin, nsq, nwr, nbusy, feed_at, blk_next;
        bit aborted;
        n = ref_words(cm, dd);
        r = ref_rate(cm);
        exp_sq  = (n > 0) ? (n - 1) / r : 0;
        exp_fin = (n == 0) ? 1 : n + 2 + exp_sq * gap;
        fin = -1; nsq = 0; nwr = 0; nbusy = 0; feed_at = -1; blk_next = 1; aborted = 0;
        got_q.delete();
        @(negedge clk);
        cmode = 3'(cm);
        d = 11'(dd);
        state_i = blk_q[0];
        state_vld = 1'b1;
        for (int c = 1; c <= 600; c++) begin
            @(negedge clk);
            state_vld = 1'b0;
            if (ready) got_q.push_back(dt_o_hash);
            if (wr_en) nwr++;
            if (busy) nbusy++;
            if (squeeze_req) begin
                nsq++;
                feed_at = c + gap - 1;
            end
            if (finish_hash) begin
                fin = c;
                break;
            end
            if (c == feed_at && blk_next < blk_q.size()) begin
                state_i = blk_q[blk_next];
                blk_next++;
                state_vld = 1'b1;
            end
            if (c == disturb_at) begin
                state_vld = 1'b1;
                cmode = 3'd3;
                state_i = rand_blk();
            end
            if (c == disturb_at + 1) begin
                cmode = 3'd5;
                d = 11'd2047;
            end
            if (c == rst_at) begin
                rst_n = 1'b0;
                #1;
                chk({name, "_rst_outs"},
                    {27'd0, squeeze_req, busy, wr_en, ready, finish_hash, dt_o_hash}, 64'd0);
                for (int j = 0; j < 3; j++) begin
                    @(negedge clk);
                    chk({name, "_rst_quiet"}, {62'd0, finish_hash, wr_en}, 64'd0);
                end
                rst_n = 1'b1;
                aborted = 1;
                break;
            end
        end
        if (aborted) return;
        chk({name, "_fin_cycle"}, 64'(fin), 64'(exp_fin));
        chk({name, "_ready_beats"}, 64'(got_q.size()), 64'((n == 0) ? 0 : n + 1));
        chk({name, "_sqz_reqs"}, 64'(nsq), 64'(exp_sq));
        chk({name, "_wr_en_cycles"}, 64'(nwr), 64'(exp_fin));
        chk({name, "_busy_cycles"}, 64'(nbusy), 64'(exp_fin));
        if (got_q.size() > 0) chk({name, "_lead"}, 64'(got_q[0]), 64'd0);
        for (int k = 0; k < n; k++) begin
            if (k + 1 < got_q.size())
                chk($sformatf("%s_w%0d", name, k), 64'(got_q[k+1]), 64'(ref_word(k, r)));
        end
        @(negedge clk);
        chk({name, "_closed"}, {61'd0, wr_en, busy, finish_hash}, 64'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        cmode = '0;
        d = '0;
        state_i = '0;
        state_vld = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_outs", {27'd0, squeeze_req, busy, wr_en, ready, finish_hash, dt_o_hash}, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        blk_q = '{ramp_blk(0)};
        run_session("t1", 1, 0, 1, -1, -1);
        chk("t1_first", 64'(got_at(1)), 64'h00010203);
        chk("t1_last", 64'(got_at(8)), 64'h1c1d1e1f);
        t1_q = got_q;

        run_session("t2a", 0, 0, 1, -1, -1);
        chk("t2a_last", 64'(got_at(7)), 64'h18191a1b);
        run_session("t2b", 3, 0, 1, -1, -1);
        chk("t2b_last", 64'(got_at(16)), 64'h3c3d3e3f);

        blk_q = '{ramp_blk(0), ramp_blk(1)};
        run_session("t3", 4, 2047, 5, -1, -1);
        chk("t3_blk0_last", 64'(got_at(42)), 64'ha4a5a6a7);
        chk("t3_blk1_first", 64'(got_at(43)), 64'hfffefdfc);

        blk_q = '{ramp_blk(0)};
        run_session("t4a", 5, 31, 1, -1, -1);
        run_session("t4b", 6, 0, 1, -1, -1);

        run_session("t5", 1, 0, 1, 4, -1);
        chk("t5_len_vs_t1", 64'(got_q.size()), 64'(t1_q.size()));
        for (int k = 0; k < t1_q.size(); k++)
            chk($sformatf("t5_vs_t1_%0d", k), 64'(got_at(k)), 64'(t1_q[k]));

        run_session("t6_abort", 1, 0, 1, -1, 5);
        @(negedge clk);
        run_session("t6_fresh", 1, 0, 1, -1, -1);
        for (int k = 0; k < t1_q.size(); k++)
            chk($sformatf("t6_vs_t1_%0d", k), 64'(got_at(k)), 64'(t1_q[k]));

        for (int s = 0; s < 12; s++) begin
            int cm, dd, gap;
            cm  = $urandom_range(0, 7);
            dd  = $urandom_range(0, 2047);
            gap = $urandom_range(1, 6);
            blk_q = '{rand_blk(), rand_blk(), rand_blk()};
            run_session($sformatf("rnd%0d", s), cm, dd, gap, -1, -1);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
